// File: rtl/proc_pkg.sv
// Shared fetch-stage types and constants.
// Holds fetch_state_t, INSTR_W and PC_STEP; no ports.
package proc_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between fetch stage and memory.
// master: drives ImemReq/ImemAddr, takes ImemRdata/ImemRvalid.
interface fetch_unit_if;
    import proc_pkg::*;

    logic               ImemReq;
    logic [INSTR_W-1:0] ImemAddr;
    logic [INSTR_W-1:0] ImemRdata;
    logic               ImemRvalid;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemRdata,
        input  ImemRvalid
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemRdata,
        output ImemRvalid
    );

endinterface

// File: rtl/pc_reg.sv
// Program-counter register with synchronous reset and load enable.
// Ports: CLK, Reset, en_i (load), d_i (next value), q_o (PC).
module pc_reg
    import proc_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_VAL = '0
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               en_i,
    input  logic [INSTR_W-1:0] d_i,
    output logic [INSTR_W-1:0] q_o
);

    logic [INSTR_W-1:0] pc_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q <= RESET_VAL;
        end else if (en_i) begin
            pc_q <= d_i;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, reads imem, holds Instr until acked.
// Ports: CLK, Reset, imem (master bus), Instr/InstrValid/InstrAck,
// PCSrc/Result (branch target), PC, PCPlus8, FetchFault.
// Optional macro FETCH_TIMEOUT_EN adds the FETCH timeout and FAULT.
module fetch_unit
    import proc_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned        TIMEOUT_CYCLES = 16
) (
    input  logic               CLK,
    input  logic               Reset,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    input  logic               InstrAck,
    input  logic               PCSrc,
    input  logic [INSTR_W-1:0] Result,
    output logic [INSTR_W-1:0] PC,
    output logic [INSTR_W-1:0] PCPlus8,
    output logic               FetchFault
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_nxt;
    logic               pc_ld;

    // Target low bits are always word-aligned away.
    logic [1:0] unused_res_lsb;
    assign unused_res_lsb = Result[1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    localparam logic [7:0] unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    pc_reg #(
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .CLK   (CLK),
        .Reset (Reset),
        .en_i  (pc_ld),
        .d_i   (pc_nxt),
        .q_o   (PC)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= FETCH;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_ld   = 1'b0;
        pc_nxt  = PC + 32'(PC_STEP);
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            FETCH: begin
                if (imem.ImemRvalid) begin
                    instr_d = imem.ImemRdata;
                    state_d = ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TO_LIMIT) begin
                        state_d = FAULT;
                    end
                end
`endif
            end
            ISSUE: begin
                if (InstrAck) begin
                    pc_ld   = 1'b1;
                    state_d = FETCH;
                    if (PCSrc) begin
                        pc_nxt = {Result[31:2], 2'b00};
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Each new FETCH gets a full timeout budget.
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                // FAULT is only left through Reset.
                state_d = state_q;
            end
        endcase
    end

    assign imem.ImemReq  = (state_q == FETCH);
    assign imem.ImemAddr = PC;
    assign Instr         = instr_q;
    assign InstrValid    = (state_q == ISSUE);
    assign PCPlus8       = PC + 32'd8;

`ifdef FETCH_TIMEOUT_EN
    assign FetchFault = (state_q == FAULT);
`else
    assign FetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a PC/instruction model.
// Build with FETCH_TIMEOUT_EN to exercise the timeout fault path.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 4;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        InstrAck;
    logic        PCSrc;
    logic [31:0] Result;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic        FetchFault;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_pc;

    fetch_unit_if mem ();

    fetch_unit #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .imem       (mem),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .InstrAck   (InstrAck),
        .PCSrc      (PCSrc),
        .Result     (Result),
        .PC         (PC),
        .PCPlus8    (PCPlus8),
        .FetchFault (FetchFault)
    );

    always #5 CLK = ~CLK;

    // Drive-only: zero-wait fetch of d followed by an immediate ack.
    task automatic fetch_ack(input logic [31:0] d);
        mem.ImemRvalid = 1'b1;
        mem.ImemRdata  = d;
        @(negedge CLK);
        mem.ImemRvalid = 1'b0;
        InstrAck       = 1'b1;
        PCSrc          = 1'b0;
        @(negedge CLK);
        InstrAck       = 1'b0;
        exp_pc         = exp_pc + 32'd4;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        exp_pc = RST_PC;
        total++;
        if (PC !== exp_pc) begin
            bad++;
            $display("FAIL reset_pc got=%h exp=%h", PC, exp_pc);
        end
        total++;
        if ({InstrValid, FetchFault} !== 2'b00) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00",
                     {InstrValid, FetchFault});
        end
        total++;
        if (Instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_instr got=%h exp=0", Instr);
        end
        total++;
        if (mem.ImemReq !== 1'b1 || mem.ImemAddr !== exp_pc) begin
            bad++;
            $display("FAIL reset_req got=%b/%h exp=1/%h",
                     mem.ImemReq, mem.ImemAddr, exp_pc);
        end
        total++;
        if (PCPlus8 !== exp_pc + 32'd8) begin
            bad++;
            $display("FAIL reset_pc8 got=%h exp=%h",
                     PCPlus8, exp_pc + 32'd8);
        end
        Reset = 1'b0;
    endtask

    task automatic test_seq();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem.ImemAddr !== RST_PC + 32'(4 * i)) begin
                bad++;
                $display("FAIL seq_addr got=%h exp=%h",
                         mem.ImemAddr, RST_PC + 32'(4 * i));
            end
            total++;
            if ({mem.ImemReq, InstrValid} !== 2'b10) begin
                bad++;
                $display("FAIL seq_fetch got=%b exp=10",
                         {mem.ImemReq, InstrValid});
            end
            d              = $urandom;
            mem.ImemRvalid = 1'b1;
            mem.ImemRdata  = d;
            @(negedge CLK);
            mem.ImemRvalid = 1'b0;
            total++;
            if (InstrValid !== 1'b1 || Instr !== d) begin
                bad++;
                $display("FAIL seq_issue got=%b/%h exp=1/%h",
                         InstrValid, Instr, d);
            end
            InstrAck = 1'b1;
            PCSrc    = 1'b0;
            @(negedge CLK);
            InstrAck = 1'b0;
            exp_pc   = exp_pc + 32'd4;
        end
    endtask

    task automatic test_wait();
        logic [31:0] d;
        d = $urandom;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mem.ImemReq !== 1'b1 || mem.ImemAddr !== exp_pc
                || InstrValid !== 1'b0) begin
                bad++;
                $display("FAIL wait_hold got=%b/%h/%b exp=1/%h/0",
                         mem.ImemReq, mem.ImemAddr, InstrValid, exp_pc);
            end
            mem.ImemRvalid = (k == 3);
            mem.ImemRdata  = (k == 3) ? d : $urandom;
            @(negedge CLK);
        end
        mem.ImemRvalid = 1'b0;
        total++;
        if (InstrValid !== 1'b1 || Instr !== d) begin
            bad++;
            $display("FAIL wait_data got=%b/%h exp=1/%h",
                     InstrValid, Instr, d);
        end
        InstrAck = 1'b1;
        @(negedge CLK);
        InstrAck = 1'b0;
        exp_pc   = exp_pc + 32'd4;
    endtask

    task automatic test_branch();
        Reset = 1'b1;
        @(negedge CLK);
        Reset  = 1'b0;
        exp_pc = RST_PC;
        fetch_ack($urandom);
        fetch_ack($urandom);
        mem.ImemRvalid = 1'b1;
        mem.ImemRdata  = $urandom;
        @(negedge CLK);
        mem.ImemRvalid = 1'b0;
        total++;
        if (PC !== 32'h8 || InstrValid !== 1'b1) begin
            bad++;
            $display("FAIL br_pc got=%h/%b exp=8/1", PC, InstrValid);
        end
        PCSrc    = 1'b1;
        Result   = 32'h0000_0103;
        InstrAck = 1'b1;
        @(negedge CLK);
        InstrAck = 1'b0;
        PCSrc    = 1'b0;
        total++;
        if (mem.ImemAddr !== 32'h100 || mem.ImemReq !== 1'b1) begin
            bad++;
            $display("FAIL br_addr got=%h/%b exp=100/1",
                     mem.ImemAddr, mem.ImemReq);
        end
        total++;
        if (PCPlus8 !== 32'h108) begin
            bad++;
            $display("FAIL br_pc8 got=%h exp=108", PCPlus8);
        end
        exp_pc = 32'h100;
    endtask

    task automatic test_hold();
        logic [31:0] d;
        d              = $urandom;
        mem.ImemRvalid = 1'b1;
        mem.ImemRdata  = d;
        @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({InstrValid, mem.ImemReq} !== 2'b10 || Instr !== d) begin
                bad++;
                $display("FAIL hold_stable got=%b/%h exp=10/%h",
                         {InstrValid, mem.ImemReq}, Instr, d);
            end
            mem.ImemRvalid = (k == 2);
            mem.ImemRdata  = ~d;
            @(negedge CLK);
        end
        mem.ImemRvalid = 1'b0;
        total++;
        if (InstrValid !== 1'b1 || Instr !== d) begin
            bad++;
            $display("FAIL hold_stray got=%b/%h exp=1/%h",
                     InstrValid, Instr, d);
        end
        InstrAck = 1'b1;
        @(negedge CLK);
        InstrAck = 1'b0;
        exp_pc   = exp_pc + 32'd4;
        total++;
        if ({mem.ImemReq, InstrValid} !== 2'b10
            || mem.ImemAddr !== exp_pc) begin
            bad++;
            $display("FAIL hold_next got=%b/%h exp=10/%h",
                     {mem.ImemReq, InstrValid}, mem.ImemAddr, exp_pc);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        mem.ImemRvalid = 1'b1;
        mem.ImemRdata  = $urandom;
        @(negedge CLK);
        mem.ImemRvalid = 1'b0;
        PCSrc          = 1'b1;
        Result         = 32'h0000_0041;
        InstrAck       = 1'b1;
        @(negedge CLK);
        InstrAck = 1'b0;
        PCSrc    = 1'b0;
        total++;
        if (PC !== 32'h40) begin
            bad++;
            $display("FAIL rm_pc got=%h exp=40", PC);
        end
        repeat (2) @(negedge CLK);
        Reset          = 1'b1;
        mem.ImemRvalid = 1'b1;
        mem.ImemRdata  = 32'hDEAD_BEEF;
        @(negedge CLK);
        Reset          = 1'b0;
        mem.ImemRvalid = 1'b0;
        exp_pc         = RST_PC;
        total++;
        if (PC !== exp_pc || InstrValid !== 1'b0) begin
            bad++;
            $display("FAIL rm_reset got=%h/%b exp=%h/0",
                     PC, InstrValid, exp_pc);
        end
        total++;
        if (Instr !== 32'h0 || mem.ImemReq !== 1'b1) begin
            bad++;
            $display("FAIL rm_instr got=%h/%b exp=0/1",
                     Instr, mem.ImemReq);
        end
        @(negedge CLK);
        total++;
        if (InstrValid !== 1'b0) begin
            bad++;
            $display("FAIL rm_idle got=%b exp=0", InstrValid);
        end
        d              = $urandom;
        mem.ImemRvalid = 1'b1;
        mem.ImemRdata  = d;
        @(negedge CLK);
        mem.ImemRvalid = 1'b0;
        total++;
        if (InstrValid !== 1'b1 || Instr !== d) begin
            bad++;
            $display("FAIL rm_new got=%b/%h exp=1/%h",
                     InstrValid, Instr, d);
        end
        InstrAck = 1'b1;
        @(negedge CLK);
        InstrAck = 1'b0;
        exp_pc   = exp_pc + 32'd4;
    endtask

    task automatic test_random();
        int          w;
        int          hold;
        logic [31:0] d;
        logic        src;
        logic [31:0] tgt;
        for (int n = 0; n < 40; n++) begin
            w    = $urandom_range(0, 3);
            hold = $urandom_range(0, 3);
            d    = $urandom;
            for (int k = 0; k <= w; k++) begin
                total++;
                if ({mem.ImemReq, InstrValid} !== 2'b10
                    || mem.ImemAddr !== exp_pc
                    || PCPlus8 !== exp_pc + 32'd8) begin
                    bad++;
                    $display("FAIL rnd_fetch got=%b/%h/%h exp=10/%h",
                             {mem.ImemReq, InstrValid},
                             mem.ImemAddr, PCPlus8, exp_pc);
                end
                mem.ImemRvalid = (k == w);
                mem.ImemRdata  = (k == w) ? d : $urandom;
                InstrAck       = $urandom_range(0, 1);
                @(negedge CLK);
            end
            mem.ImemRvalid = 1'b0;
            for (int k = 0; k <= hold; k++) begin
                total++;
                if ({InstrValid, mem.ImemReq} !== 2'b10
                    || Instr !== d || PC !== exp_pc) begin
                    bad++;
                    $display("FAIL rnd_issue got=%b/%h/%h exp=10/%h/%h",
                             {InstrValid, mem.ImemReq}, Instr, PC,
                             d, exp_pc);
                end
                InstrAck       = (k == hold);
                src            = ($urandom_range(0, 3) == 0);
                tgt            = $urandom;
                PCSrc          = src;
                Result         = tgt;
                mem.ImemRvalid = $urandom_range(0, 1);
                mem.ImemRdata  = $urandom;
                @(negedge CLK);
            end
            InstrAck       = 1'b0;
            PCSrc          = 1'b0;
            mem.ImemRvalid = 1'b0;
            exp_pc = src ? (tgt & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        Reset = 1'b1;
        @(negedge CLK);
        Reset  = 1'b0;
        exp_pc = RST_PC;
        for (int k = 0; k < TO; k++) begin
            total++;
            if ({mem.ImemReq, FetchFault} !== 2'b10) begin
                bad++;
                $display("FAIL to_wait got=%b exp=10",
                         {mem.ImemReq, FetchFault});
            end
            @(negedge CLK);
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if ({FetchFault, mem.ImemReq, InstrValid} !== 3'b100) begin
                bad++;
                $display("FAIL to_fault got=%b exp=100",
                         {FetchFault, mem.ImemReq, InstrValid});
            end
            mem.ImemRvalid = $urandom_range(0, 1);
            InstrAck       = 1'b1;
            @(negedge CLK);
        end
        mem.ImemRvalid = 1'b0;
        InstrAck       = 1'b0;
        Reset          = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        total++;
        if ({FetchFault, mem.ImemReq} !== 2'b01 || PC !== RST_PC) begin
            bad++;
            $display("FAIL to_clear got=%b/%h exp=01/%h",
                     {FetchFault, mem.ImemReq}, PC, RST_PC);
        end
    endtask
`else
    task automatic test_no_fault();
        for (int k = 0; k < 20; k++) begin
            total++;
            if ({FetchFault, mem.ImemReq, InstrValid} !== 3'b010) begin
                bad++;
                $display("FAIL nf_wait got=%b exp=010",
                         {FetchFault, mem.ImemReq, InstrValid});
            end
            @(negedge CLK);
        end
        fetch_ack($urandom);
        total++;
        if (FetchFault !== 1'b0 || mem.ImemAddr !== exp_pc) begin
            bad++;
            $display("FAIL nf_after got=%b/%h exp=0/%h",
                     FetchFault, mem.ImemAddr, exp_pc);
        end
    endtask
`endif

    initial begin
        Reset          = 1'b1;
        InstrAck       = 1'b0;
        PCSrc          = 1'b0;
        Result         = '0;
        mem.ImemRvalid = 1'b0;
        mem.ImemRdata  = '0;
        exp_pc         = RST_PC;
        test_reset();
        test_seq();
        test_wait();
        test_branch();
        test_hold();
        test_reset_mid();
        test_random();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_fault();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
